// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for the multi-cycle MIPS-subset CPU
//
// Sequences the shared ALU, the unified instruction/data memory and the
// register file through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps, driven
// by the opcode held in the instruction register. Counts retired
// instructions and flags unsupported opcodes.
//
// Optional feature macro: MULTICYCLE_CTRL_MEM_WAIT_EN
//   defined   : FETCH, MEM_RD and MEM_WR stall until mem_ready_i = 1
//   undefined : mem_ready_i is ignored, every memory state lasts one cycle
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_i            asynchronous reset, active-high
//   ir_op_i[5:0]     IR[31:26] opcode
//   funct_i[5:0]     IR funct field (not decoded here)
//   mem_ready_i      memory access complete (wait-state build only)
//   pc_write_o       unconditional PC load
//   pc_write_cond_o  PC load qualified by ALU zero (beq)
//   i_or_d_o         memory address select: 0 = PC, 1 = ALUOut
//   mem_read_o       memory read strobe
//   mem_write_o      memory write strobe
//   ir_write_o       IR load enable
//   reg_dst_o        write register: 0 = rt, 1 = rd
//   mem_to_reg_o     write data: 0 = ALUOut, 1 = MDR
//   reg_write_o      register file write enable
//   alu_src_a_o      0 = PC, 1 = register A
//   alu_src_b_o[1:0] 00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   alu_op_o[2:0]    000 add, 001 sub, 010 lui, 011 ori, 100 R-type, 101 slt
//   pc_source_o[1:0] 00 = ALU result, 01 = ALUOut, 10 = jump target
//   state_o[3:0]     current state encoding
//   retire_o         pulse in the final state of each legal instruction
//   illegal_o        pulse when DECODE sees an unsupported opcode
//   instr_cnt_o[15:0] retired-instruction counter (wraps silently)

module multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  ir_op_i,
  input  logic [5:0]  funct_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic        i_or_d_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic [1:0]  pc_source_o,
  output logic [3:0]  state_o,
  output logic        retire_o,
  output logic        illegal_o,
  output logic [15:0] instr_cnt_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_instr_cnt;
  logic        w_mem_ready;
  logic        w_supported;
  logic        w_unused;

  // funct is decoded by the ALU control, not here; mem_ready_i is dead in
  // the single-cycle-memory build.
  assign w_unused = ^{funct_i, mem_ready_i};

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign w_mem_ready = mem_ready_i;
`else
  assign w_mem_ready = 1'b1;
`endif

  // ALU operation for the I-type arithmetic group; the opcode stays stable
  // through I_WB, so decoding it in both states holds the I_EXEC value.
  function automatic logic [2:0] i_alu_op(input logic [5:0] op);
    case (op)
      OP_ADDI: i_alu_op = 3'b000;
      OP_SLTI: i_alu_op = 3'b101;
      OP_LUI:  i_alu_op = 3'b010;
      OP_ORI:  i_alu_op = 3'b011;
      default: i_alu_op = 3'b000;
    endcase
  endfunction

  always_comb begin
    case (ir_op_i)
      OP_RTYPE, OP_ADDI, OP_SLTI, OP_BEQ, OP_LUI,
      OP_ORI, OP_LW, OP_SW, OP_J: w_supported = 1'b1;
      default:                    w_supported = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (w_mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (ir_op_i)
          OP_LW, OP_SW:                     w_next = S_MEM_ADDR;
          OP_RTYPE:                         w_next = S_R_EXEC;
          OP_BEQ:                           w_next = S_BRANCH;
          OP_J:                             w_next = S_JUMP;
          OP_ADDI, OP_SLTI, OP_LUI, OP_ORI: w_next = S_I_EXEC;
          default:                          w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: w_next = (ir_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (w_mem_ready) w_next = S_MEM_WB;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   if (w_mem_ready) w_next = S_FETCH;
      S_R_EXEC:   w_next = S_R_WB;
      S_R_WB:     w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_I_EXEC:   w_next = S_I_WB;
      S_I_WB:     w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  // State register and retired-instruction counter. Reset drops straight
  // back to FETCH, so an interrupted instruction never retires or counts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_FETCH;
      r_instr_cnt <= 16'd0;
    end else begin
      r_state <= w_next;
      if (retire_o) r_instr_cnt <= r_instr_cnt + 16'd1;
    end
  end

  // Moore output decode. The FETCH strobes must be visible in the very
  // cycle reset is released, so outputs follow the state register
  // directly and are blanked while rst_i is high (the reset state itself
  // is FETCH).
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    alu_op_o        = 3'b000;
    pc_source_o     = 2'b00;
    retire_o        = 1'b0;
    illegal_o       = 1'b0;
    if (!rst_i) begin
      case (r_state)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          // IR and PC load only on the completing cycle of a stalled fetch
          ir_write_o  = w_mem_ready;
          pc_write_o  = w_mem_ready;
          alu_src_b_o = 2'b01;
          pc_source_o = 2'b00;
        end
        S_DECODE: begin
          alu_src_b_o = 2'b11;
          illegal_o   = ~w_supported;
        end
        S_MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          alu_op_o    = 3'b000;
        end
        S_MEM_RD: begin
          mem_read_o = 1'b1;
          i_or_d_o   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
          reg_dst_o    = 1'b0;
          retire_o     = 1'b1;
        end
        S_MEM_WR: begin
          mem_write_o = 1'b1;
          i_or_d_o    = 1'b1;
          retire_o    = w_mem_ready;
        end
        S_R_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b00;
          alu_op_o    = 3'b100;
        end
        S_R_WB: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
          retire_o    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o     = 1'b1;
          alu_src_b_o     = 2'b00;
          alu_op_o        = 3'b001;
          pc_write_cond_o = 1'b1;
          pc_source_o     = 2'b01;
          retire_o        = 1'b1;
        end
        S_JUMP: begin
          pc_write_o  = 1'b1;
          pc_source_o = 2'b10;
          retire_o    = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          alu_op_o    = i_alu_op(ir_op_i);
        end
        S_I_WB: begin
          reg_write_o  = 1'b1;
          reg_dst_o    = 1'b0;
          mem_to_reg_o = 1'b0;
          alu_op_o     = i_alu_op(ir_op_i);
          retire_o     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o     = r_state;
  assign instr_cnt_o = r_instr_cnt;

endmodule
